// File: rtl/dino_sprite_layer_if.sv
// Bus between the Dino pixel pipeline and the player-sprite layer.
//   master : timing generator / ROM side; drives beam position, frame tick,
//            jump request and the sprite-ROM pixel, and receives the layer outputs.
//   slave  : dino_sprite_layer.
// Signals:
//   i_hpos, i_vpos  [PW-1:0]  beam coordinates (coarse units)
//   i_frame_tick              one-cycle pulse per frame, inside vblank
//   i_jump                    jump request pulse
//   i_sprite_color            ROM pixel for o_rom_addr (same cycle)
//   o_color_dino              sprite pixel on
//   o_rom_addr    [AW-1:0]    {frame, row, col}
//   o_airborne                jump in progress
//   o_dino_y      [PW-1:0]    current sprite top edge
interface dino_sprite_layer_if #(
    parameter int PW = 10,
    parameter int AW = 7
);
    logic [PW-1:0] i_hpos;
    logic [PW-1:0] i_vpos;
    logic          i_frame_tick;
    logic          i_jump;
    logic          i_sprite_color;
    logic          o_color_dino;
    logic [AW-1:0] o_rom_addr;
    logic          o_airborne;
    logic [PW-1:0] o_dino_y;

    modport master (
        output i_hpos, i_vpos, i_frame_tick, i_jump, i_sprite_color,
        input  o_color_dino, o_rom_addr, o_airborne, o_dino_y
    );

    modport slave (
        input  i_hpos, i_vpos, i_frame_tick, i_jump, i_sprite_color,
        output o_color_dino, o_rom_addr, o_airborne, o_dino_y
    );
endinterface

// File: rtl/dino_sprite_layer.sv
// Animated, jumping player-sprite layer for the Dino pixel pipeline.
// Compares the beam against a movable sprite box, addresses the sprite ROM
// with {frame, row, col}, gates the ROM pixel onto o_color_dino, and runs the
// jump state machine and run-cycle animation on the per-frame tick.
// Ports:
//   clk  pixel clock
//   rst  asynchronous, active-high reset
//   bus  dino_sprite_layer_if.slave (beam position, tick, jump, ROM pixel in;
//        colour, ROM address, airborne flag, sprite top edge out)
// Beam to o_color_dino / o_rom_addr latency is one cycle.
module dino_sprite_layer #(
    parameter int CONV       = 0,
    parameter int SPR_W_LOG2 = 3,
    parameter int SPR_H_LOG2 = 3,
    parameter int FRAME_W    = 1,
    parameter int ANIM_DIV   = 8,
    parameter int X_POS      = 6,
    parameter int Y_GROUND   = 40,
    parameter int JUMP_H     = 32,
    parameter int JUMP_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    dino_sprite_layer_if.slave bus
);
    localparam int PW  = 10 - CONV;
    localparam int ADW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [PW-1:0]  X_POS_C    = PW'(X_POS);
    localparam logic [PW-1:0]  Y_GROUND_C = PW'(Y_GROUND);
    localparam logic [PW-1:0]  STEP_C     = PW'(JUMP_STEP);
    localparam logic [PW-1:0]  JUMP_H_C   = PW'(JUMP_H);
    localparam logic [PW:0]    STEP_W     = (PW+1)'(JUMP_STEP);
    localparam logic [PW:0]    JUMP_H_W   = (PW+1)'(JUMP_H);
    localparam logic [ADW-1:0] ANIM_LAST  = ADW'(ANIM_DIV - 1);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      height_q, height_d;
    logic               pend_q, pend_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [ADW-1:0]     anim_q, anim_d;
    logic [PW-1:0]      x_off_q, x_off_d;
    logic [PW-1:0]      y_off_q, y_off_d;

    logic [PW:0]        rise_sum;
    logic [PW-1:0]      dino_y;
    logic               in_sprite;
    logic               launch;

    assign dino_y = Y_GROUND_C - height_q;

    // Offsets left of / above the box wrap to large values, so checking the
    // upper bits for zero is the unsigned "< 2^LOG2" test.
    assign in_sprite = (x_off_q[PW-1:SPR_W_LOG2] == '0) &&
                       (y_off_q[PW-1:SPR_H_LOG2] == '0);

    assign bus.o_color_dino = in_sprite & bus.i_sprite_color;
    assign bus.o_rom_addr   = {frame_q, y_off_q[SPR_H_LOG2-1:0], x_off_q[SPR_W_LOG2-1:0]};
    assign bus.o_airborne   = (state_q != GROUND);
    assign bus.o_dino_y     = dino_y;

    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        frame_d  = frame_q;
        anim_d   = anim_q;
        x_off_d  = bus.i_hpos - X_POS_C;
        y_off_d  = bus.i_vpos - dino_y;
        // Requests only latch while grounded; a request arriving with the tick
        // counts for that tick.
        pend_d   = pend_q | (bus.i_jump && (state_q == GROUND));
        launch   = pend_q | bus.i_jump;
        rise_sum = {1'b0, height_q} + STEP_W;

        if (bus.i_frame_tick) begin
            pend_d = 1'b0;
            unique case (state_q)
                GROUND: begin
                    if (launch) begin
                        state_d  = RISE;
                        height_d = STEP_C;
                        frame_d  = '0;
                        anim_d   = '0;
                    end else begin
                        height_d = '0;
                        if (anim_q == ANIM_LAST) begin
                            anim_d  = '0;
                            frame_d = frame_q + 1'b1;
                        end else begin
                            anim_d = anim_q + 1'b1;
                        end
                    end
                end
                RISE: begin
                    if (rise_sum >= JUMP_H_W) begin
                        state_d  = FALL;
                        height_d = JUMP_H_C;
                    end else begin
                        height_d = rise_sum[PW-1:0];
                    end
                end
                FALL: begin
                    if (height_q <= STEP_C) begin
                        state_d  = GROUND;
                        height_d = '0;
                    end else begin
                        height_d = height_q - STEP_C;
                    end
                end
                default: begin
                    state_d  = GROUND;
                    height_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GROUND;
            height_q <= '0;
            pend_q   <= 1'b0;
            frame_q  <= '0;
            anim_q   <= '0;
            x_off_q  <= '1;
            y_off_q  <= '1;
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
            pend_q   <= pend_d;
            frame_q  <= frame_d;
            anim_q   <= anim_d;
            x_off_q  <= x_off_d;
            y_off_q  <= y_off_d;
        end
    end
endmodule

// File: tb/tb_dino_sprite_layer.sv
// Directed self-checking bench for dino_sprite_layer: default instance (A)
// plus a swept-parameter instance (B: CONV=1, 16-wide box, 4 frames, step 5).
module tb_dino_sprite_layer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int   b_exp[14] = '{35, 30, 25, 20, 15, 10, 8, 13, 18, 23, 28, 33, 38, 40};

    dino_sprite_layer_if #(.PW(10), .AW(7)) ifa ();
    dino_sprite_layer_if #(.PW(9),  .AW(9)) ifb ();

    dino_sprite_layer u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dino_sprite_layer #(
        .CONV       (1),
        .SPR_W_LOG2 (4),
        .FRAME_W    (2),
        .JUMP_STEP  (5),
        .JUMP_H     (32)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_a();
        ifa.i_frame_tick = 1'b1;
        step();
        ifa.i_frame_tick = 1'b0;
    endtask

    task automatic tick_b();
        ifb.i_frame_tick = 1'b1;
        step();
        ifb.i_frame_tick = 1'b0;
    endtask

    initial begin
        int exp_y;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        ifa.i_hpos = '0; ifa.i_vpos = '0; ifa.i_frame_tick = 1'b0;
        ifa.i_jump = 1'b0; ifa.i_sprite_color = 1'b1;
        ifb.i_hpos = '0; ifb.i_vpos = '0; ifb.i_frame_tick = 1'b0;
        ifb.i_jump = 1'b0; ifb.i_sprite_color = 1'b1;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_airborne", ifa.o_airborne, 0);
        check("rst_dino_y",   ifa.o_dino_y, 40);
        check("rst_color",    ifa.o_color_dino, 0);
        check("rst_rom_addr", ifa.o_rom_addr, 7'h3F);
        check("rst_b_dino_y", ifb.o_dino_y, 40);
        @(negedge clk);
        rst = 1'b0;

        // Static hit box, one cycle late
        for (int h = 0; h <= 20; h++) begin
            for (int v = 35; v <= 52; v++) begin
                ifa.i_hpos = 10'(h);
                ifa.i_vpos = 10'(v);
                step();
                check("box_a", ifa.o_color_dino,
                      ((h >= 6) && (h <= 13) && (v >= 40) && (v <= 47)) ? 1 : 0);
            end
        end
        ifa.i_hpos = 10'd9; ifa.i_vpos = 10'd42;
        step();
        check("rom_addr_9_42", ifa.o_rom_addr, 7'h13);

        // Grounded animation: frame flips every 8 ticks
        for (int n = 1; n <= 24; n++) begin
            tick_a();
            check("anim_frame", ifa.o_rom_addr[6], ((n / 8) % 2));
        end

        // Jump between ticks: launches on the next tick only
        ifa.i_jump = 1'b1;
        step();
        ifa.i_jump = 1'b0;
        step();
        check("pend_no_early_launch", ifa.o_airborne, 0);
        check("pend_no_early_y", ifa.o_dino_y, 40);
        for (int k = 1; k <= 16; k++) begin
            tick_a();
            exp_y = (k <= 8) ? (40 - 4 * k) : (40 - 4 * (16 - k));
            check("traj_y", ifa.o_dino_y, exp_y);
            check("traj_airborne", ifa.o_airborne, (k < 16) ? 1 : 0);
            check("traj_frame0", ifa.o_rom_addr[6], 0);
            if (k == 8) begin
                for (int v = 6; v <= 17; v++) begin
                    ifa.i_hpos = 10'd9;
                    ifa.i_vpos = 10'(v);
                    step();
                    check("apex_box", ifa.o_color_dino, ((v >= 8) && (v <= 15)) ? 1 : 0);
                end
            end
        end

        // Jump in the same cycle as a tick, plus a discarded request in FALL
        ifa.i_jump = 1'b1;
        ifa.i_frame_tick = 1'b1;
        step();
        ifa.i_jump = 1'b0;
        ifa.i_frame_tick = 1'b0;
        check("same_cycle_airborne", ifa.o_airborne, 1);
        check("same_cycle_y", ifa.o_dino_y, 36);
        for (int k = 2; k <= 16; k++) begin
            tick_a();
            if (k == 10) begin
                ifa.i_jump = 1'b1;
                step();
                ifa.i_jump = 1'b0;
            end
        end
        check("land_y", ifa.o_dino_y, 40);
        check("land_airborne", ifa.o_airborne, 0);
        tick_a();
        check("fall_req_discarded", ifa.o_airborne, 0);
        check("fall_req_y", ifa.o_dino_y, 40);

        // Reset mid-jump
        ifa.i_jump = 1'b1;
        step();
        ifa.i_jump = 1'b0;
        for (int k = 1; k <= 5; k++) tick_a();
        check("mid_jump_y", ifa.o_dino_y, 20);
        ifa.i_hpos = 10'd9; ifa.i_vpos = 10'd22;
        step();
        check("mid_jump_hit", ifa.o_color_dino, 1);
        rst = 1'b1;
        #1;
        check("midrst_airborne", ifa.o_airborne, 0);
        check("midrst_y", ifa.o_dino_y, 40);
        check("midrst_color", ifa.o_color_dino, 0);
        check("midrst_rom_addr", ifa.o_rom_addr, 7'h3F);
        #2 rst = 1'b0;
        ifa.i_vpos = 10'd42;
        #1;
        check("post_rst_color", ifa.o_color_dino, 0);
        step();
        check("post_rst_hit", ifa.o_color_dino, 1);

        // Instance B: 16-wide box and wrap-around probes
        for (int h = 0; h <= 25; h++) begin
            ifb.i_hpos = 9'(h);
            ifb.i_vpos = 9'd42;
            step();
            check("box_b", ifb.o_color_dino, ((h >= 6) && (h <= 21)) ? 1 : 0);
        end
        ifb.i_hpos = 9'd9; ifb.i_vpos = 9'd42;
        step();
        check("rom_addr_b", ifb.o_rom_addr, 9'h023);

        // Instance B: trajectory with clamped apex
        ifb.i_jump = 1'b1;
        step();
        ifb.i_jump = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick_b();
            check("traj_b_y", ifb.o_dino_y, b_exp[k-1]);
            check("traj_b_airborne", ifb.o_airborne, (k < 14) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dino_sprite_layer.md
# dino_sprite_layer

Parametrised, animated, jumping player-sprite layer for the Dino pixel pipeline. It compares the beam position against a movable sprite box and drives a sprite-ROM address of `{frame, row, col}`. It gates the ROM pixel onto a dedicated colour output. It also owns the jump state machine and the run-cycle animation counter, both updated only on the per-frame tick. The block sits between the VGA timing generator and the colour mux, beside the obstacle and ground layers.

## Interface
- `CONV`, 0: position LSBs dropped; beam coordinates are `[9:CONV]`, and PW = 10-CONV.
- `SPR_W_LOG2`, 3: sprite width is 2^SPR_W_LOG2 coarse pixels.
- `SPR_H_LOG2`, 3: sprite height is 2^SPR_H_LOG2 coarse pixels.
- `FRAME_W`, 1: animation frame index width (2^FRAME_W frames).
- `ANIM_DIV`, 8: frame ticks per animation step (≥1).
- `X_POS`, 6: sprite left edge (coarse units).
- `Y_GROUND`, 40: sprite top edge when grounded.
- `JUMP_H`, 32: apex height. Must satisfy JUMP_H ≤ Y_GROUND.
- `JUMP_STEP`, 4: height change per tick (≥1).
- `clk` in 1 pixel clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_hpos` in PW: beam x.
- `i_vpos` in PW: beam y.
- `i_frame_tick` in 1: one-cycle pulse, once per frame, inside vblank.
- `i_jump` in 1: jump request pulse, accepted in any cycle.
- `i_sprite_color` in 1: ROM pixel for `o_rom_addr`, combinational, same cycle.
- `o_color_dino` out 1: sprite pixel on.
- `o_rom_addr` out FRAME_W+SPR_H_LOG2+SPR_W_LOG2: `{frame, row, col}`.
- `o_airborne` out 1: jump state ≠ GROUND.
- `o_dino_y` out PW: current sprite top edge, Y_GROUND − height.

## Operation
- **Offset stage (registered):**
  - `x_off_r <= i_hpos − X_POS`
  - `y_off_r <= i_vpos − o_dino_y`
  - Both are PW-bit modulo subtractions.
- **Hit test:** `in_sprite = (x_off_r < 2^SPR_W_LOG2) && (y_off_r < 2^SPR_H_LOG2)`, unsigned. Beam positions left of or above the box wrap to large values and miss.
- **ROM address:** `o_rom_addr = {frame, y_off_r[SPR_H_LOG2-1:0], x_off_r[SPR_W_LOG2-1:0]}`.
- **Colour:** `o_color_dino = in_sprite & i_sprite_color`. Combinational from registers and ROM data.
- **Jump request latch:**
  - `pend` is set by `i_jump` in any cycle.
  - `pend` is cleared on every `i_frame_tick`, whether or not the request was consumed.
  - When `i_jump` and `i_frame_tick` arrive in the same cycle, the request counts for that tick.
  - Requests made while airborne are discarded.
- **Jump FSM** (states GROUND, RISE, FALL; `height` is a PW-bit register). All transitions happen only on `i_frame_tick`:
  - GROUND: if `pend`, then `height = JUMP_STEP` and go to RISE. Otherwise hold with `height = 0`.
  - RISE: if `height + JUMP_STEP ≥ JUMP_H`, then `height = JUMP_H` and go to FALL. Otherwise `height += JUMP_STEP`. Compute the sum at PW+1 bits so it cannot overflow.
  - FALL: if `height ≤ JUMP_STEP`, then `height = 0` and go to GROUND. Otherwise `height −= JUMP_STEP`.
- **Animation:**
  - While GROUND, each tick increments `anim_div`.
  - When `anim_div` reaches ANIM_DIV−1, reset it to 0 and increment `frame` modulo 2^FRAME_W.
  - While RISE or FALL, `frame` and `anim_div` are both held at 0.
- **Tear-free motion:** `o_dino_y` changes only on ticks, which fall in vblank, so the sprite never tears.

## Timing
- **Latency:** beam position to `o_color_dino` and `o_rom_addr` is 1 cycle. The colour mux must delay the other layers to match.
- **FSM and frame timing:** the jump FSM, `o_airborne`, `o_dino_y` and `frame` update on the clock edge that samples `i_frame_tick`=1. The new `o_dino_y` feeds `y_off_r` from the next cycle onward.
- **Reset values** (asynchronous, immediate, including mid-jump):
  - state GROUND, `height` 0, `pend` 0, `frame` 0, `anim_div` 0.
  - `x_off_r` and `y_off_r` all-ones, which puts them outside the box.
  - Outputs: `o_color_dino`=0, `o_airborne`=0, `o_dino_y`=Y_GROUND, `o_rom_addr`={0, all-ones, all-ones}.
- **Jump duration:** with the defaults a jump lasts 16 ticks.
  - Heights go 4, 8 … 32 (apex on tick 8), then 28 … 4, then 0 on tick 16.
  - `o_airborne` is high from after tick 1 until after tick 16.

## Test plan
- **Reset mid-jump:** assert `rst` at tick 5 of a jump. `o_airborne`=0, `o_dino_y`=40 and `o_color_dino`=0 immediately. With ROM tied to 1, the first cycle after release still gives 0.
- **Static hit box:** defaults, ROM tied to 1, sweep (hpos, vpos) over 0..20 × 35..52. `o_color_dino`=1 exactly for hpos 6..13 and vpos 40..47, one cycle late. At (9,42) `o_rom_addr`=`{0,3'd2,3'd3}`.
- **Full jump trajectory:** pulse `i_jump` then issue 16 ticks. `o_dino_y` sequence is 36,32,…,8 (apex, `o_airborne`=1), then 12,…,36, then 40 with `o_airborne`=0. A sprite drawn at tick 8 spans vpos 8..15.
- **Request edge cases:**
  - `i_jump` in the same cycle as a tick: launches on that tick.
  - `i_jump` during FALL: no second jump after landing.
  - `i_jump` between ticks: launches at the next tick only.
- **Animation:** grounded, 24 ticks. `frame` steps 0→1 at tick 8, 1→0 at tick 16, 0→1 at tick 24. A jump forces `frame` to 0 and holds it there until landing.
- **Parameter sweep:**
  - CONV=1, SPR_W_LOG2=4, FRAME_W=2, JUMP_STEP=5, JUMP_H=32: rise heights 5,10,…,30, then 32 (clamped). Fall heights 27,…,2, then 0. The hit box is 16 wide.
  - Run wrap-around probes at hpos 0..5, which must not hit.
